// File: rtl/gci_host_model.sv
// gci_host_model
// Bring-up model of the GCI host side that connects to the mist1032sa GCI port.
// After reset it waits P_INIT_DELAY cycles and then sends the boot size
// handshake. After that it serves core read and write requests against a
// 16-word register file. It also raises timed interrupts and holds each one
// until the core acknowledges it.
//
// Ports:
//   iCLOCK        clock
//   iRESET_SYNC   synchronous active-high reset
//   iGCI_REQ      core request valid      oGCI_BUSY   model cannot accept
//   iGCI_RW       0 = read, 1 = write     iGCI_ADDR   byte address
//   iGCI_DATA     write data
//   oGCI_REQ      return data valid       iGCI_BUSY   core cannot accept
//   oGCI_DATA     return / handshake data
//   oGCI_IRQ_REQ  interrupt request       oGCI_IRQ_NUM interrupt number
//   iGCI_IRQ_ACK  interrupt acknowledge   oINIT_DONE  size handshake done
//
// Register map (word index = ADDR[5:2]; ADDR[31:6] must be zero):
//   R0-R12 storage, R13 lost-IRQ count (RO, saturating 8-bit),
//   R14 IRQ number ([5:0] used), R15 IRQ timer (reads remaining count).
module gci_host_model #(
  parameter logic [31:0] P_GCI_SIZE   = 32'h0001_0000,
  parameter int          P_INIT_DELAY = 32,
  parameter int          P_REG_DEPTH  = 16
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iGCI_REQ,
  output logic        oGCI_BUSY,
  input  logic        iGCI_RW,
  input  logic [31:0] iGCI_ADDR,
  input  logic [31:0] iGCI_DATA,
  output logic        oGCI_REQ,
  input  logic        iGCI_BUSY,
  output logic [31:0] oGCI_DATA,
  output logic        oGCI_IRQ_REQ,
  output logic [5:0]  oGCI_IRQ_NUM,
  input  logic        iGCI_IRQ_ACK,
  output logic        oINIT_DONE
);

  typedef enum logic [1:0] {
    INIT_WAIT,
    INIT_SEND,
    IDLE,
    RD_RET
  } state_t;

  localparam logic [3:0] IDX_LOST  = 4'd13;
  localparam logic [3:0] IDX_IRQN  = 4'd14;
  localparam logic [3:0] IDX_TIMER = 4'd15;

  state_t      state;
  logic [31:0] init_cnt;
  logic [31:0] regs [0:P_REG_DEPTH-1];
  logic [31:0] timer;
  logic [7:0]  lost_cnt;

  logic [3:0]  idx;
  logic        addr_ok;
  logic        accept;
  logic        wr_en;
  logic        timer_wr;
  logic        expire;
  logic [31:0] rd_val;
  logic        unused_addr_lsb;

  assign idx             = iGCI_ADDR[5:2];
  assign addr_ok         = (iGCI_ADDR[31:6] == 26'd0);
  assign accept          = (state == IDLE) && iGCI_REQ;
  assign wr_en           = accept && iGCI_RW && addr_ok;
  assign timer_wr        = wr_en && (idx == IDX_TIMER);
  // A timer write on the 1 -> 0 edge reloads the counter, so that edge does not count as an expiry.
  assign expire          = !timer_wr && (timer == 32'd1);
  assign unused_addr_lsb = ^iGCI_ADDR[1:0];

  always_comb begin
    rd_val = 32'd0;
    if (addr_ok) begin
      case (idx)
        IDX_LOST:  rd_val = {24'd0, lost_cnt};
        IDX_TIMER: rd_val = timer;
        default:   rd_val = regs[idx];
      endcase
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state        <= INIT_WAIT;
      init_cnt     <= 32'd0;
      oGCI_BUSY    <= 1'b1;
      oGCI_REQ     <= 1'b0;
      oGCI_DATA    <= 32'd0;
      oINIT_DONE   <= 1'b0;
      oGCI_IRQ_REQ <= 1'b0;
      oGCI_IRQ_NUM <= 6'd0;
      timer        <= 32'd0;
      lost_cnt     <= 8'd0;
      for (int i = 0; i < P_REG_DEPTH; i++) regs[i] <= 32'd0;
    end else begin
      // Timer: a write (including 0 = cancel) takes priority over the count-down.
      if (timer_wr)
        timer <= iGCI_DATA;
      else if (timer != 32'd0)
        timer <= timer - 32'd1;

      // If an IRQ is still pending when the timer expires, that expiry is lost.
      // This also applies on the edge where the pending IRQ is acknowledged.
      if (expire && oGCI_IRQ_REQ && (lost_cnt != 8'hFF))
        lost_cnt <= lost_cnt + 8'd1;

      if (oGCI_IRQ_REQ && iGCI_IRQ_ACK) begin
        oGCI_IRQ_REQ <= 1'b0;
      end else if (expire && !oGCI_IRQ_REQ) begin
        oGCI_IRQ_REQ <= 1'b1;
        oGCI_IRQ_NUM <= regs[IDX_IRQN][5:0];
      end

      if (wr_en && (idx != IDX_LOST) && (idx != IDX_TIMER))
        regs[idx] <= iGCI_DATA;

      case (state)
        INIT_WAIT: begin
          if (init_cnt == 32'(P_INIT_DELAY - 1)) begin
            state     <= INIT_SEND;
            oGCI_REQ  <= 1'b1;
            oGCI_DATA <= P_GCI_SIZE;
          end else begin
            init_cnt <= init_cnt + 32'd1;
          end
        end
        INIT_SEND: begin
          if (!iGCI_BUSY) begin
            state      <= IDLE;
            oGCI_REQ   <= 1'b0;
            oGCI_BUSY  <= 1'b0;
            oINIT_DONE <= 1'b1;
          end
        end
        IDLE: begin
          if (accept && !iGCI_RW) begin
            state     <= RD_RET;
            oGCI_REQ  <= 1'b1;
            oGCI_DATA <= rd_val;
            oGCI_BUSY <= 1'b1;
          end
        end
        RD_RET: begin
          if (!iGCI_BUSY) begin
            state     <= IDLE;
            oGCI_REQ  <= 1'b0;
            oGCI_BUSY <= 1'b0;
          end
        end
        default: state <= INIT_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_gci_host_model.sv
// Testbench for gci_host_model. It drives stimulus on the falling edge and
// samples on the falling edge. Read results are checked against expected
// values queued at issue time.
module tb_gci_host_model;

  logic        clk = 1'b0;
  logic        rst;
  logic        gci_req;
  logic        busy_o;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        req_o;
  logic        core_busy;
  logic [31:0] data_o;
  logic        irq_req;
  logic [5:0]  irq_num;
  logic        irq_ack;
  logic        init_done;

  int checks   = 0;
  int failures = 0;
  int xfer_cnt = 0;

  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  gci_host_model dut (
    .iCLOCK      (clk),
    .iRESET_SYNC (rst),
    .iGCI_REQ    (gci_req),
    .oGCI_BUSY   (busy_o),
    .iGCI_RW     (rw),
    .iGCI_ADDR   (addr),
    .iGCI_DATA   (wdata),
    .oGCI_REQ    (req_o),
    .iGCI_BUSY   (core_busy),
    .oGCI_DATA   (data_o),
    .oGCI_IRQ_REQ(irq_req),
    .oGCI_IRQ_NUM(irq_num),
    .iGCI_IRQ_ACK(irq_ack),
    .oINIT_DONE  (init_done)
  );

  // Count completed return transfers (REQ high while the core is not busy).
  always @(posedge clk)
    if (!rst && req_o && !core_busy) xfer_cnt <= xfer_cnt + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic wait_idle();
    int n = 0;
    while (busy_o !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL idle_timeout: got busy=%b expected 0 within 200 cycles", busy_o);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wait_idle();
    gci_req = 1'b1; rw = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    gci_req = 1'b0; rw = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output bit to);
    int n = 0;
    to = 1'b0;
    wait_idle();
    gci_req = 1'b1; rw = 1'b0; addr = a;
    @(negedge clk);
    gci_req = 1'b0;
    while (req_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    d = data_o;
    if (n >= 50) to = 1'b1;
    else @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; gci_req = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    core_busy = 1'b1; irq_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL rst_busy: got %b expected 1", busy_o); end
    checks++; if (req_o !== 1'b0) begin failures++; $display("FAIL rst_req: got %b expected 0", req_o); end
    checks++; if (data_o !== 32'd0) begin failures++; $display("FAIL rst_data: got %h expected 0", data_o); end
    checks++; if (irq_req !== 1'b0 || irq_num !== 6'd0) begin failures++; $display("FAIL rst_irq: got %b/%h expected 0/00", irq_req, irq_num); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL rst_init_done: got %b expected 0", init_done); end
  endtask

  // Release reset with the core busy and check that the size word waits at edge 32 until BUSY drops.
  task automatic test_boot();
    int x0;
    rst = 1'b0;
    repeat (31) @(negedge clk);
    checks++; if (req_o !== 1'b0) begin failures++; $display("FAIL boot_early: got req=%b expected 0 at edge 31", req_o); end
    @(negedge clk);
    checks++; if (req_o !== 1'b1 || data_o !== 32'h0001_0000) begin failures++; $display("FAIL boot_rise: got req=%b data=%h expected 1/00010000", req_o, data_o); end
    repeat (8) @(negedge clk);
    checks++; if (req_o !== 1'b1 || data_o !== 32'h0001_0000 || init_done !== 1'b0) begin failures++; $display("FAIL boot_hold: got req=%b data=%h done=%b expected 1/00010000/0", req_o, data_o, init_done); end
    x0 = xfer_cnt;
    core_busy = 1'b0;
    @(negedge clk);
    checks++; if (req_o !== 1'b0 || init_done !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("FAIL boot_done: got req=%b done=%b busy=%b expected 0/1/0", req_o, init_done, busy_o); end
    repeat (3) @(negedge clk);
    checks++; if (xfer_cnt !== x0 + 1 || init_done !== 1'b1) begin failures++; $display("FAIL boot_single: got %0d transfers done=%b expected 1/1", xfer_cnt - x0, init_done); end
  endtask

  task automatic test_reg_path();
    logic [31:0] d, e;
    bit to;
    int x0;
    bus_write(32'h14, 32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    wait_idle();
    core_busy = 1'b1; gci_req = 1'b1; rw = 1'b0; addr = 32'h14;
    @(negedge clk);
    gci_req = 1'b0;
    x0 = xfer_cnt;
    d = data_o;
    for (int i = 0; i < 3; i++) begin
      checks++; if (req_o !== 1'b1 || data_o !== d) begin failures++; $display("FAIL hold_stable: got req=%b data=%h expected 1/%h", req_o, data_o, d); end
      @(negedge clk);
    end
    core_busy = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL rd_r5: got %h expected %h", d, e); end
    checks++; if (req_o !== 1'b0 || xfer_cnt !== x0 + 1) begin failures++; $display("FAIL single_xfer: got req=%b xfers=%0d expected 0/1", req_o, xfer_cnt - x0); end
    // Out-of-range write must be dropped and must not alias onto R0.
    bus_write(32'h40, 32'h1234_5678);
    exp_q.push_back(32'd0);
    bus_read(32'h40, d, to); e = exp_q.pop_front();
    checks++; if (to || d !== e) begin failures++; $display("FAIL rd_oob: got %h expected %h", d, e); end
    exp_q.push_back(32'd0);
    bus_read(32'h00, d, to); e = exp_q.pop_front();
    checks++; if (to || d !== e) begin failures++; $display("FAIL rd_r0_alias: got %h expected %h", d, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e;
    bit to;
    for (int i = 0; i < 4; i++) bus_write(32'(i * 4), 32'hA500_0000 + 32'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA500_0000 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      bus_read(32'(i * 4), d, to); e = exp_q.pop_front();
      checks++; if (to || d !== e) begin failures++; $display("FAIL b2b_r%0d: got %h expected %h", i, d, e); end
    end
  endtask

  task automatic test_timer_irq();
    bus_write(32'h38, 32'h0000_002A);
    bus_write(32'h3C, 32'd10);
    repeat (9) @(negedge clk);
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL irq_early: got %b expected 0", irq_req); end
    @(negedge clk);
    checks++; if (irq_req !== 1'b1 || irq_num !== 6'h2A) begin failures++; $display("FAIL irq_rise: got %b/%h expected 1/2a", irq_req, irq_num); end
    repeat (5) @(negedge clk);
    checks++; if (irq_req !== 1'b1) begin failures++; $display("FAIL irq_hold: got %b expected 1", irq_req); end
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL irq_ack: got %b expected 0", irq_req); end
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL ack_idle: got %b expected 0", irq_req); end
  endtask

  task automatic test_lost_irq();
    logic [31:0] d, e;
    bit to;
    bus_write(32'h3C, 32'd3);
    repeat (3) @(negedge clk);
    checks++; if (irq_req !== 1'b1) begin failures++; $display("FAIL lost_pending: got %b expected 1", irq_req); end
    bus_write(32'h3C, 32'd3);
    repeat (5) @(negedge clk);
    exp_q.push_back(32'd1);
    bus_read(32'h34, d, to); e = exp_q.pop_front();
    checks++; if (to || d !== e) begin failures++; $display("FAIL lost_one: got %h expected %h", d, e); end
    for (int i = 0; i < 300; i++) begin
      bus_write(32'h3C, 32'd1);
      @(negedge clk);
    end
    exp_q.push_back(32'h0000_00FF);
    bus_read(32'h34, d, to); e = exp_q.pop_front();
    checks++; if (to || d !== e) begin failures++; $display("FAIL lost_sat: got %h expected %h", d, e); end
    bus_write(32'h34, 32'd0);
    exp_q.push_back(32'h0000_00FF);
    bus_read(32'h34, d, to); e = exp_q.pop_front();
    checks++; if (to || d !== e) begin failures++; $display("FAIL lost_ro: got %h expected %h", d, e); end
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  task automatic test_cancel_collision();
    logic [31:0] d, e;
    bit to;
    bit seen;
    bus_write(32'h3C, 32'd100);
    exp_q.push_back(32'd100);
    bus_read(32'h3C, d, to); e = exp_q.pop_front();
    checks++; if (to || d !== e) begin failures++; $display("FAIL timer_read: got %0d expected %0d", d, e); end
    bus_write(32'h3C, 32'd5);
    @(negedge clk);
    bus_write(32'h3C, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (irq_req !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL cancel: got irq=1 expected no irq"); end
    // Reload on the expiry edge: 4 is written at edge k and 3 at edge k+4, so the IRQ is due after edge k+7.
    bus_write(32'h38, 32'h0000_0011);
    bus_write(32'h3C, 32'd4);
    repeat (3) @(negedge clk);
    bus_write(32'h3C, 32'd3);
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL collide_expiry: got %b expected 0", irq_req); end
    repeat (2) @(negedge clk);
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL collide_early: got %b expected 0", irq_req); end
    @(negedge clk);
    checks++; if (irq_req !== 1'b1 || irq_num !== 6'h11) begin failures++; $display("FAIL collide_reload: got %b/%h expected 1/11", irq_req, irq_num); end
  endtask

  task automatic test_mid_read_reset();
    logic [31:0] d, e;
    bit to;
    int n;
    int x0;
    bus_write(32'h3C, 32'd50);
    wait_idle();
    core_busy = 1'b1; gci_req = 1'b1; rw = 1'b0; addr = 32'h0;
    @(negedge clk);
    gci_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy_o !== 1'b1 || req_o !== 1'b0 || data_o !== 32'd0) begin failures++; $display("FAIL mrst_bus: got busy=%b req=%b data=%h expected 1/0/0", busy_o, req_o, data_o); end
    checks++; if (irq_req !== 1'b0 || irq_num !== 6'd0 || init_done !== 1'b0) begin failures++; $display("FAIL mrst_irq: got %b/%h done=%b expected 0/00/0", irq_req, irq_num, init_done); end
    core_busy = 1'b0;
    x0 = xfer_cnt;
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (init_done !== 1'b1 || xfer_cnt !== x0 + 1) begin failures++; $display("FAIL mrst_handshake: got done=%b xfers=%0d expected 1/1", init_done, xfer_cnt - x0); end
    for (int i = 0; i < 16; i++) exp_q.push_back(32'd0);
    for (int i = 0; i < 16; i++) begin
      bus_read(32'(i * 4), d, to); e = exp_q.pop_front();
      checks++; if (to || d !== e) begin failures++; $display("FAIL mrst_r%0d: got %h expected %h", i, d, e); end
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_reg_path();
    test_back_to_back();
    test_timer_irq();
    test_lost_irq();
    test_cancel_collision();
    test_mid_read_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
